// File: rtl/dcache_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dcache_pkg
//  Description : Shared constants and state encoding for the n-way data cache.
//                Optional statistics state is present only when
//                DCACHE_STATS_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
package dcache_pkg;

   localparam int          WORD_W         = 32;
   localparam int          BYTE_OFF       = 2;
   localparam logic [31:0] STATS_ADDR_DEF = 32'h0000_3100;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      WB        = 3'd1,
      FETCH     = 3'd2,
      FLUSH_CHK = 3'd3,
      FLUSH_WB  = 3'd4,
`ifdef DCACHE_STATS_EN
      STATS     = 3'd5,
`endif
      DONE      = 3'd6
   } dcache_state_t;

endpackage
`default_nettype wire

// File: rtl/dcache_nway_if.sv
`default_nettype none
// ============================================================================
//  Module      : dcache_nway_if
//  Description : Datapath-side and memory-side signal bundle of the cache.
//                The cache uses the slave view; the datapath/memory side uses
//                the master view.
//  Revision    : 1.0 - initial release
// ============================================================================
interface dcache_nway_if;
   import dcache_pkg::*;

   logic              halt;
   logic              dmemREN;
   logic              dmemWEN;
   logic [WORD_W-1:0] dmemaddr;
   logic [WORD_W-1:0] dmemstore;
   logic              dhit;
   logic [WORD_W-1:0] dmemload;
   logic              flushed;
   logic              dREN;
   logic              dWEN;
   logic [WORD_W-1:0] daddr;
   logic [WORD_W-1:0] dstore;
   logic [WORD_W-1:0] dload;
   logic              dwait;

   modport slave (
      input  halt, dmemREN, dmemWEN, dmemaddr, dmemstore, dload, dwait,
      output dhit, dmemload, flushed, dREN, dWEN, daddr, dstore
   );

   modport master (
      output halt, dmemREN, dmemWEN, dmemaddr, dmemstore, dload, dwait,
      input  dhit, dmemload, flushed, dREN, dWEN, daddr, dstore
   );

endinterface
`default_nettype wire

// File: rtl/dcache_lru.sv
`default_nettype none
// ============================================================================
//  Module      : dcache_lru
//  Description : True-LRU age tracking per set. Age 0 is most recent, age
//                WAYS-1 is the replacement candidate; invalid ways win first.
//  Revision    : 1.0 - initial release
// ============================================================================
module dcache_lru #(
   parameter  int SETS = 8,
   parameter  int WAYS = 2,
   localparam int IB   = $clog2(SETS),
   localparam int WW   = (WAYS > 1) ? $clog2(WAYS) : 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          touch_en,
   input  logic [IB-1:0] touch_set,
   input  logic [WW-1:0] touch_way,
   input  logic [IB-1:0] query_set,
   input  logic [WAYS-1:0] valid_mask,
   output logic [WW-1:0] victim_way
);

   logic [WW-1:0] age_q [SETS][WAYS];
   logic [WW-1:0] age_d [SETS][WAYS];
   logic          found_inv;

   // Touched way becomes age 0; ways younger than its old age each grow by one.
   always_comb begin
      age_d = age_q;
      if (touch_en) begin
         for (int w = 0; w < WAYS; w++) begin
            if (WW'(w) == touch_way)
               age_d[touch_set][w] = '0;
            else if (age_q[touch_set][w] < age_q[touch_set][touch_way])
               age_d[touch_set][w] = age_q[touch_set][w] + 1'b1;
         end
      end
   end

   // Victim: lowest-index invalid way, else the oldest way.
   always_comb begin
      victim_way = '0;
      found_inv  = 1'b0;
      for (int w = 0; w < WAYS; w++) begin
         if (!valid_mask[w] && !found_inv) begin
            victim_way = WW'(w);
            found_inv  = 1'b1;
         end
      end
      if (!found_inv) begin
         for (int w = 0; w < WAYS; w++) begin
            if (age_q[query_set][w] == WW'(WAYS - 1))
               victim_way = WW'(w);
         end
      end
   end

   // Ages start as the way index so each set begins as a permutation.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++)
               age_q[s][w] <= WW'(w);
      end else begin
         age_q <= age_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/dcache_nway.sv
`default_nettype none
// ============================================================================
//  Module      : dcache_nway
//  Description : Write-back, write-allocate n-way data cache with burst
//                fill/writeback and halt-triggered flush. Defining
//                DCACHE_STATS_EN adds hit/miss counters written out at the
//                end of the flush.
//  Revision    : 1.0 - initial release
// ============================================================================
module dcache_nway
   import dcache_pkg::*;
#(
   parameter int          SETS        = 8,
   parameter int          WAYS        = 2,
   parameter int          BLOCK_WORDS = 2,
   parameter logic [31:0] STATS_ADDR  = STATS_ADDR_DEF
) (
   input  logic         CLK,
   input  logic         nRST,
   dcache_nway_if.slave bus
);

   localparam int OB    = $clog2(BLOCK_WORDS);
   localparam int OBW   = (OB > 0) ? OB : 1;
   localparam int IB    = $clog2(SETS);
   localparam int WW    = (WAYS > 1) ? $clog2(WAYS) : 1;
   localparam int TAG_W = WORD_W - BYTE_OFF - OB - IB;

   localparam logic [OBW-1:0] LAST_WORD = OBW'(BLOCK_WORDS - 1);
   localparam logic [IB-1:0]  LAST_SET  = IB'(SETS - 1);
   localparam logic [WW-1:0]  LAST_WAY  = WW'(WAYS - 1);

   localparam logic [2:0] S_IDLE      = IDLE;
   localparam logic [2:0] S_WB        = WB;
   localparam logic [2:0] S_FETCH     = FETCH;
   localparam logic [2:0] S_FLUSH_CHK = FLUSH_CHK;
   localparam logic [2:0] S_FLUSH_WB  = FLUSH_WB;
`ifdef DCACHE_STATS_EN
   localparam logic [2:0] S_STATS     = STATS;
`endif
   localparam logic [2:0] S_DONE      = DONE;

   logic [TAG_W-1:0]  tag_q   [WAYS][SETS];
   logic [TAG_W-1:0]  tag_d   [WAYS][SETS];
   logic              valid_q [WAYS][SETS];
   logic              valid_d [WAYS][SETS];
   logic              dirty_q [WAYS][SETS];
   logic              dirty_d [WAYS][SETS];
   logic [WORD_W-1:0] data_q  [WAYS][SETS][BLOCK_WORDS];
   logic [WORD_W-1:0] data_d  [WAYS][SETS][BLOCK_WORDS];

   logic [2:0]     state_q, state_d;
   logic [OBW-1:0] cnt_q, cnt_d;
   logic [WW-1:0]  victim_q, victim_d;
   logic [IB-1:0]  fset_q, fset_d;
   logic [WW-1:0]  fway_q, fway_d;
   logic           fill_done_q, fill_done_d;
`ifdef DCACHE_STATS_EN
   logic [31:0]    hits_q, hits_d, misses_q, misses_d;
`endif

   logic [TAG_W-1:0]  req_tag;
   logic [IB-1:0]     req_idx;
   logic [OBW-1:0]    req_off;
   logic [3:0]        match_cnt;
   logic [WW-1:0]     hit_way;
   logic              dhit;
   logic [WAYS-1:0]   set_valid;
   logic [WW-1:0]     lru_victim;
   logic              touch_en;
   logic [WW-1:0]     touch_way;
   logic              dren, dwen;
   logic [WORD_W-1:0] daddr, dstore;

   // Byte address of one word of a line.
   function automatic logic [31:0] line_addr(input logic [TAG_W-1:0] t,
                                             input logic [IB-1:0]    i,
                                             input logic [OBW-1:0]   w);
      line_addr = (32'(t) << (BYTE_OFF + OB + IB)) |
                  (32'(i) << (BYTE_OFF + OB)) |
                  (32'(w) << BYTE_OFF);
   endfunction

   assign req_tag = bus.dmemaddr[WORD_W-1 -: TAG_W];
   assign req_idx = bus.dmemaddr[BYTE_OFF + OB +: IB];

   generate
      if (OB > 0) begin : g_word_off
         assign req_off = bus.dmemaddr[BYTE_OFF +: OBW];
      end else begin : g_single_word
         assign req_off = '0;
      end
   endgenerate

   // Tag compare across all ways; a hit needs exactly one valid match.
   always_comb begin
      match_cnt = '0;
      hit_way   = '0;
      set_valid = '0;
      for (int w = 0; w < WAYS; w++) begin
         set_valid[w] = valid_q[w][req_idx];
         if (valid_q[w][req_idx] && (tag_q[w][req_idx] == req_tag)) begin
            match_cnt = match_cnt + 4'd1;
            hit_way   = WW'(w);
         end
      end
   end

   assign dhit = (state_q == S_IDLE) && !bus.halt &&
                 (bus.dmemREN || bus.dmemWEN) && (match_cnt == 4'd1);

   dcache_lru #(.SETS(SETS), .WAYS(WAYS)) u_lru (
      .clk        (CLK),
      .rst_n      (nRST),
      .touch_en   (touch_en),
      .touch_set  (req_idx),
      .touch_way  (touch_way),
      .query_set  (req_idx),
      .valid_mask (set_valid),
      .victim_way (lru_victim)
   );

   // Controller: hit service, miss bursts, flush walk and line updates.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      victim_d    = victim_q;
      fset_d      = fset_q;
      fway_d      = fway_q;
      fill_done_d = 1'b0;
      tag_d       = tag_q;
      valid_d     = valid_q;
      dirty_d     = dirty_q;
      data_d      = data_q;
      touch_en    = 1'b0;
      touch_way   = '0;
      dren        = 1'b0;
      dwen        = 1'b0;
      daddr       = '0;
      dstore      = '0;
`ifdef DCACHE_STATS_EN
      hits_d      = hits_q;
      misses_d    = misses_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (bus.halt) begin
               state_d = S_FLUSH_CHK;
               fset_d  = '0;
               fway_d  = '0;
            end else if (dhit) begin
               touch_en  = 1'b1;
               touch_way = hit_way;
               if (bus.dmemWEN) begin
                  data_d[hit_way][req_idx][req_off] = bus.dmemstore;
                  dirty_d[hit_way][req_idx]         = 1'b1;
               end
`ifdef DCACHE_STATS_EN
               if (!fill_done_q) hits_d = hits_q + 32'd1;
`endif
            end else if (bus.dmemREN || bus.dmemWEN) begin
               victim_d = lru_victim;
               cnt_d    = '0;
               state_d  = (valid_q[lru_victim][req_idx] && dirty_q[lru_victim][req_idx])
                          ? S_WB : S_FETCH;
`ifdef DCACHE_STATS_EN
               misses_d = misses_q + 32'd1;
`endif
            end
         end
         S_WB: begin
            dwen   = 1'b1;
            daddr  = line_addr(tag_q[victim_q][req_idx], req_idx, cnt_q);
            dstore = data_q[victim_q][req_idx][cnt_q];
            if (!bus.dwait) begin
               if (cnt_q == LAST_WORD) begin
                  dirty_d[victim_q][req_idx] = 1'b0;
                  cnt_d   = '0;
                  state_d = S_FETCH;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         S_FETCH: begin
            dren  = 1'b1;
            daddr = line_addr(req_tag, req_idx, cnt_q);
            if (!bus.dwait) begin
               data_d[victim_q][req_idx][cnt_q] = bus.dload;
               if (cnt_q == LAST_WORD) begin
                  tag_d[victim_q][req_idx]   = req_tag;
                  valid_d[victim_q][req_idx] = 1'b1;
                  dirty_d[victim_q][req_idx] = 1'b0;
                  touch_en    = 1'b1;
                  touch_way   = victim_q;
                  fill_done_d = 1'b1;
                  cnt_d       = '0;
                  state_d     = S_IDLE;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         S_FLUSH_CHK: begin
            cnt_d = '0;
            if (valid_q[fway_q][fset_q] && dirty_q[fway_q][fset_q]) begin
               state_d = S_FLUSH_WB;
            end else if ((fset_q == LAST_SET) && (fway_q == LAST_WAY)) begin
`ifdef DCACHE_STATS_EN
               state_d = S_STATS;
`else
               state_d = S_DONE;
`endif
            end else if (fway_q == LAST_WAY) begin
               fway_d = '0;
               fset_d = fset_q + 1'b1;
            end else begin
               fway_d = fway_q + 1'b1;
            end
         end
         S_FLUSH_WB: begin
            dwen   = 1'b1;
            daddr  = line_addr(tag_q[fway_q][fset_q], fset_q, cnt_q);
            dstore = data_q[fway_q][fset_q][cnt_q];
            if (!bus.dwait) begin
               if (cnt_q == LAST_WORD) begin
                  // Line is clean now; FLUSH_CHK will step past it.
                  dirty_d[fway_q][fset_q] = 1'b0;
                  cnt_d   = '0;
                  state_d = S_FLUSH_CHK;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
`ifdef DCACHE_STATS_EN
         S_STATS: begin
            dwen   = 1'b1;
            daddr  = cnt_q[0] ? (STATS_ADDR + 32'd4) : STATS_ADDR;
            dstore = cnt_q[0] ? misses_q : hits_q;
            if (!bus.dwait) begin
               if (cnt_q[0]) state_d = S_DONE;
               else          cnt_d   = OBW'(1);
            end
         end
`endif
         S_DONE: begin
            state_d = S_DONE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign bus.dhit     = dhit;
   assign bus.dmemload = dhit ? data_q[hit_way][req_idx][req_off] : '0;
   assign bus.flushed  = (state_q == S_DONE);
   assign bus.dREN     = dren;
   assign bus.dWEN     = dwen;
   assign bus.daddr    = daddr;
   assign bus.dstore   = dstore;

   // State and line storage; reset clears everything so requests abort at once.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         victim_q    <= '0;
         fset_q      <= '0;
         fway_q      <= '0;
         fill_done_q <= 1'b0;
         tag_q       <= '{default: '0};
         valid_q     <= '{default: '0};
         dirty_q     <= '{default: '0};
         data_q      <= '{default: '0};
`ifdef DCACHE_STATS_EN
         hits_q      <= '0;
         misses_q    <= '0;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         victim_q    <= victim_d;
         fset_q      <= fset_d;
         fway_q      <= fway_d;
         fill_done_q <= fill_done_d;
         tag_q       <= tag_d;
         valid_q     <= valid_d;
         dirty_q     <= dirty_d;
         data_q      <= data_d;
`ifdef DCACHE_STATS_EN
         hits_q      <= hits_d;
         misses_q    <= misses_d;
`endif
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_dcache_nway.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dcache_nway
//  Description : Directed bench for dcache_nway. DUT A is 8 sets x 2 ways,
//                DUT B is 4 sets x 4 ways; both use 2-word lines. Memory
//                returns the word address as data. Stats checks apply when
//                DCACHE_STATS_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dcache_nway;

   logic        clk = 1'b0;
   logic        nrst;
   logic        halt_a;
   logic        ren_a, wen_a, ren_b, wen_b;
   logic [31:0] req_addr, req_data;
   logic        dwait_a;
   logic        slow;

   int tests = 0;
   int fails = 0;

   int          rd_cnt_a = 0;
   int          wr_n_a   = 0;
   int          wr_n_b   = 0;
   int          stab_err = 0;
   logic [31:0] wr_addr [16];
   logic [31:0] wr_data [16];
   logic        have_prev = 1'b0;
   logic [31:0] prev_addr, prev_store;
   int          wcnt = 0;

   int          lat;
   logic [31:0] rd;
   int          n;

   always #5 clk = ~clk;

   dcache_nway_if if_a ();
   dcache_nway_if if_b ();

   assign if_a.halt      = halt_a;
   assign if_a.dmemREN   = ren_a;
   assign if_a.dmemWEN   = wen_a;
   assign if_a.dmemaddr  = req_addr;
   assign if_a.dmemstore = req_data;
   assign if_a.dload     = if_a.daddr;
   assign if_a.dwait     = dwait_a;

   assign if_b.halt      = 1'b0;
   assign if_b.dmemREN   = ren_b;
   assign if_b.dmemWEN   = wen_b;
   assign if_b.dmemaddr  = req_addr;
   assign if_b.dmemstore = req_data;
   assign if_b.dload     = if_b.daddr;
   assign if_b.dwait     = 1'b0;

   dcache_nway #(.SETS(8), .WAYS(2), .BLOCK_WORDS(2)) u_dut_a (
      .CLK  (clk),
      .nRST (nrst),
      .bus  (if_a.slave)
   );

   dcache_nway #(.SETS(4), .WAYS(4), .BLOCK_WORDS(2)) u_dut_b (
      .CLK  (clk),
      .nRST (nrst),
      .bus  (if_b.slave)
   );

   // Slow memory on A: each word waits 3 cycles before it is accepted.
   always @(negedge clk) begin
      if (slow && (if_a.dREN || if_a.dWEN)) begin
         if (wcnt == 3) begin dwait_a = 1'b0; wcnt = 0; end
         else           begin dwait_a = 1'b1; wcnt = wcnt + 1; end
      end else begin
         dwait_a = 1'b0;
         wcnt    = 0;
      end
   end

   // Memory-side monitor, sampled just before each rising edge.
   always begin
      @(negedge clk);
      #4;
      if (if_a.dREN && !if_a.dwait) rd_cnt_a = rd_cnt_a + 1;
      if (if_a.dWEN && !if_a.dwait) begin
         if (wr_n_a < 16) begin
            wr_addr[wr_n_a] = if_a.daddr;
            wr_data[wr_n_a] = if_a.dstore;
         end
         wr_n_a = wr_n_a + 1;
      end
      if (if_a.dREN || if_a.dWEN) begin
         if (have_prev && ((if_a.daddr != prev_addr) ||
                           (if_a.dWEN && (if_a.dstore != prev_store))))
            stab_err = stab_err + 1;
         if (if_a.dwait) begin
            prev_addr  = if_a.daddr;
            prev_store = if_a.dstore;
            have_prev  = 1'b1;
         end else begin
            have_prev  = 1'b0;
         end
      end else begin
         have_prev = 1'b0;
      end
      if (if_b.dWEN && !if_b.dwait) wr_n_b = wr_n_b + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests = tests + 1;
      assert (obs === exp) else begin
         fails = fails + 1;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One datapath request held until dhit (or a cycle budget runs out).
   task automatic access(input bit sel_b, input logic [31:0] addr, input bit we,
                         input logic [31:0] wd, output int l, output logic [31:0] r);
      @(negedge clk);
      req_addr = addr;
      req_data = wd;
      if (sel_b) begin ren_b = !we; wen_b = we; end
      else       begin ren_a = !we; wen_a = we; end
      l = 0;
      #1;
      while (!(sel_b ? if_b.dhit : if_a.dhit) && (l < 200)) begin
         @(negedge clk);
         #1;
         l = l + 1;
      end
      r = sel_b ? if_b.dmemload : if_a.dmemload;
      @(negedge clk);
      ren_a = 1'b0; wen_a = 1'b0; ren_b = 1'b0; wen_b = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      nrst = 1'b0; halt_a = 1'b0; slow = 1'b0; dwait_a = 1'b0;
      ren_a = 1'b0; wen_a = 1'b0; ren_b = 1'b0; wen_b = 1'b0;
      req_addr = '0; req_data = '0;
      #12;
      check("rst_dhit",     if_a.dhit,     32'd0);
      check("rst_flushed",  if_a.flushed,  32'd0);
      check("rst_dren",     if_a.dREN,     32'd0);
      check("rst_dwen",     if_a.dWEN,     32'd0);
      check("rst_daddr",    if_a.daddr,    32'd0);
      check("rst_dstore",   if_a.dstore,   32'd0);
      check("rst_dmemload", if_a.dmemload, 32'd0);
      @(negedge clk);
      nrst = 1'b1;

      // Cold read miss and neighbouring word
      access(0, 32'h40, 0, 0, lat, rd);
      check("cold_lat",  lat, 32'd3);
      check("cold_data", rd,  32'h40);
      check("cold_rdcnt", rd_cnt_a, 32'd2);
      access(0, 32'h44, 0, 0, lat, rd);
      check("w1_lat",  lat, 32'd0);
      check("w1_data", rd,  32'h44);

      // Write hit then read back, no memory traffic
      access(0, 32'h44, 1, 32'hDEADBEEF, lat, rd);
      check("wr_hit_lat", lat, 32'd0);
      access(0, 32'h44, 0, 0, lat, rd);
      check("rdback_lat",  lat, 32'd0);
      check("rdback_data", rd,  32'hDEADBEEF);
      check("no_traffic_rd", rd_cnt_a, 32'd2);
      check("no_traffic_wr", wr_n_a,   32'd0);

      // Second tag in set 0, then dirty-victim eviction with slow memory
      access(0, 32'h80, 0, 0, lat, rd);
      check("tagB_lat",  lat, 32'd3);
      check("tagB_data", rd,  32'h80);
      slow = 1'b1;
      access(0, 32'hC0, 0, 0, lat, rd);
      slow = 1'b0;
      check("evict_lat",  lat, 32'd17);
      check("evict_data", rd,  32'hC0);
      check("evict_wrn",  wr_n_a,   32'd2);
      check("evict_wa0",  wr_addr[0], 32'h40);
      check("evict_wd0",  wr_data[0], 32'h40);
      check("evict_wa1",  wr_addr[1], 32'h44);
      check("evict_wd1",  wr_data[1], 32'hDEADBEEF);
      check("evict_rdcnt", rd_cnt_a, 32'd6);
      check("stable_bus", stab_err,  32'd0);
      access(0, 32'h84, 0, 0, lat, rd);
      check("B_resident_lat",  lat, 32'd0);
      check("B_resident_data", rd,  32'h84);

      // Three dirty lines for the flush
      access(0, 32'h84, 1, 32'h11111111, lat, rd);
      check("dirty1_lat", lat, 32'd0);
      access(0, 32'h48, 1, 32'h22222222, lat, rd);
      check("dirty2_lat", lat, 32'd3);
      access(0, 32'h0C, 1, 32'h33333333, lat, rd);
      check("dirty3_lat", lat, 32'd3);

      // Halt: pending hit is suppressed, then flush runs to completion
      @(negedge clk);
      halt_a = 1'b1; ren_a = 1'b1; req_addr = 32'h84;
      #1;
      check("halt_blocks_hit", if_a.dhit,    32'd0);
      check("halt_not_done",   if_a.flushed, 32'd0);
      @(negedge clk);
      ren_a = 1'b0;
      n = 0;
      #1;
      while (!if_a.flushed && (n < 200)) begin
         @(negedge clk);
         #1;
         n = n + 1;
      end
      check("flushed_set", if_a.flushed, 32'd1);
`ifdef DCACHE_STATS_EN
      check("flush_wrn", wr_n_a, 32'd10);
`else
      check("flush_wrn", wr_n_a, 32'd8);
`endif
      check("fl_a2", wr_addr[2], 32'h80);  check("fl_d2", wr_data[2], 32'h80);
      check("fl_a3", wr_addr[3], 32'h84);  check("fl_d3", wr_data[3], 32'h11111111);
      check("fl_a4", wr_addr[4], 32'h48);  check("fl_d4", wr_data[4], 32'h22222222);
      check("fl_a5", wr_addr[5], 32'h4C);  check("fl_d5", wr_data[5], 32'h4C);
      check("fl_a6", wr_addr[6], 32'h08);  check("fl_d6", wr_data[6], 32'h08);
      check("fl_a7", wr_addr[7], 32'h0C);  check("fl_d7", wr_data[7], 32'h33333333);
`ifdef DCACHE_STATS_EN
      check("stats_hit_addr",  wr_addr[8], 32'h3100);
      check("stats_hit_val",   wr_data[8], 32'd5);
      check("stats_miss_addr", wr_addr[9], 32'h3104);
      check("stats_miss_val",  wr_data[9], 32'd5);
`endif
      repeat (5) @(negedge clk);
      #1;
      check("flushed_hold", if_a.flushed, 32'd1);
      check("done_dren",    if_a.dREN,    32'd0);
      check("done_dwen",    if_a.dWEN,    32'd0);
`ifdef DCACHE_STATS_EN
      check("done_no_more_wr", wr_n_a, 32'd10);
`else
      check("done_no_more_wr", wr_n_a, 32'd8);
`endif

      // 4-way LRU: tags 0,1,2,3,0,4 at set 0 evict tag 1
      access(1, 32'h04, 0, 0, lat, rd);  check("b_t0_lat", lat, 32'd3);
      check("b_t0_data", rd, 32'h04);
      access(1, 32'h24, 0, 0, lat, rd);  check("b_t1_lat", lat, 32'd3);
      access(1, 32'h44, 0, 0, lat, rd);  check("b_t2_lat", lat, 32'd3);
      access(1, 32'h64, 0, 0, lat, rd);  check("b_t3_lat", lat, 32'd3);
      access(1, 32'h04, 0, 0, lat, rd);  check("b_t0_rehit", lat, 32'd0);
      access(1, 32'h84, 0, 0, lat, rd);  check("b_t4_lat", lat, 32'd3);
      check("b_t4_data", rd, 32'h84);
      access(1, 32'h04, 0, 0, lat, rd);  check("b_t0_kept", lat, 32'd0);
      access(1, 32'h44, 0, 0, lat, rd);  check("b_t2_kept", lat, 32'd0);
      access(1, 32'h64, 0, 0, lat, rd);  check("b_t3_kept", lat, 32'd0);
      check("b_t3_data", rd, 32'h64);
      access(1, 32'h84, 0, 0, lat, rd);  check("b_t4_kept", lat, 32'd0);
      access(1, 32'h24, 0, 0, lat, rd);  check("b_t1_evicted", lat, 32'd3);
      check("b_t1_data", rd, 32'h24);
      check("b_no_wb", wr_n_b, 32'd0);

      // Reset in the middle of a fill drops the memory request at once
      @(negedge clk);
      req_addr = 32'hA4; ren_b = 1'b1;
      @(negedge clk);
      @(negedge clk);
      #1;
      check("abort_dren_before", if_b.dREN, 32'd1);
      #1;
      nrst = 1'b0;
      #1;
      check("abort_dren_after", if_b.dREN,    32'd0);
      check("abort_dwen_after", if_b.dWEN,    32'd0);
      check("abort_daddr",      if_b.daddr,   32'd0);
      check("abort_flushed_a",  if_a.flushed, 32'd0);
      ren_b = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/dcache_nway.md
Name: dcache_nway

Overview:
- Parametrised write-back, write-allocate data cache between the datapath and the memory controller.
- Configurable set count, associativity and block size.
- True-LRU replacement per set.
- Multi-word burst fill and writeback, with a halt-triggered flush that walks every line.
- Optional hit/miss statistics written to memory at the end of the flush.

Parameters:
- SETS, 8, number of sets; power of 2, 2..64.
- WAYS, 2, associativity; power of 2, 1..8.
- BLOCK_WORDS, 2, 32-bit words per line; power of 2, 1..8.
- STATS_ADDR, 32'h00003100, word address where the hit count is written during flush (statistics build only).

Ports:
- CLK  in  1  clock
- nRST  in  1  asynchronous active-low reset
- halt  in  1  datapath halt request; level, sticky
- dmemREN  in  1  datapath read request
- dmemWEN  in  1  datapath write request; never asserted together with dmemREN
- dmemaddr  in  32  byte address; bits [1:0] ignored
- dmemstore  in  32  write data
- dhit  out  1  request satisfied this cycle
- dmemload  out  32  read data; valid when dhit
- flushed  out  1  flush complete
- dREN  out  1  memory read
- dWEN  out  1  memory write
- daddr  out  32  memory word address
- dstore  out  32  memory write data
- dload  in  32  memory read data
- dwait  in  1  memory busy; a word transfers on a cycle with dREN|dWEN=1 and dwait=0

Behaviour:
- Address split: [1:0] byte; next OB=log2(BLOCK_WORDS) bits word offset; next IB=log2(SETS) bits index; remaining bits tag.
- Line state: tag, valid, dirty, BLOCK_WORDS data words.
- Reset clears every bit of every line, all LRU ages, all counters and the state.
- Outputs at reset: dhit, flushed, dREN and dWEN are 0; daddr, dstore and dmemload are 0.
- dhit is combinational and asserted only in IDLE, when (dmemREN|dmemWEN) and exactly one valid way matches the tag.
- dmemload is the hitting way's word; it is 0 when dhit=0.
- Write hit: the word and dirty=1 are written at the clock edge.
- Any hit makes the hit way most-recent.
- LRU uses per-set age counters of log2(WAYS) bits each.
  - The accessed way's age is set to 0.
  - Ways younger than its old age are incremented.
  - Ages always form a permutation.
- Victim selection: the lowest-index invalid way; otherwise the way with age WAYS-1.
- FSM states: IDLE, WB, FETCH, FLUSH_CHK, FLUSH_WB, STATS, DONE.
- IDLE transitions, in priority order:
  - halt goes to FLUSH_CHK; an outstanding request is dropped and dhit is forced 0 while halt=1.
  - A hit stays in IDLE.
  - A miss whose victim is valid and dirty goes to WB.
  - Any other miss goes to FETCH.
- WB:
  - dWEN=1; daddr = {victim tag, index, word counter, 2'b00}; dstore = victim word.
  - The word counter advances on each !dwait.
  - After the last word: victim dirty=0, go to FETCH.
- FETCH:
  - dREN=1, daddr built from the request tag.
  - Each accepted dload is written into the victim way's word slot.
  - After the last word: tag is written, valid=1, dirty=0, the way becomes most-recent, return to IDLE.
  - The held request then hits on the following cycle; read-miss latency is (WB words) + BLOCK_WORDS + 1 cycles at zero wait.
- Nothing in the line is updated while dwait holds a word; daddr and dstore stay stable.
- FLUSH_CHK:
  - Visits (set, way) in ascending order, one cycle each.
  - A valid dirty line goes to FLUSH_WB, which writes BLOCK_WORDS words like WB and then clears dirty.
  - After the last line: go to STATS if statistics are built, else DONE.
- DONE: flushed=1, with no memory requests, until reset.
- Counters wrap at 2^32.
- Reset mid-burst aborts the transaction immediately; memory sees dREN and dWEN fall asynchronously.

Optional Feature:
- Macro: DCACHE_STATS_EN.
- Defined:
  - 32-bit hit and miss counters are kept.
  - The hit counter increments on a dhit that is not the post-fill hit.
  - The miss counter increments on each IDLE→WB/FETCH transition.
  - STATS writes the hit count to STATS_ADDR and the miss count to STATS_ADDR+4 before DONE.
- Undefined:
  - No counters and no STATS state.
  - FLUSH_CHK goes straight to DONE.

Decomposition:
- Package dcache_pkg holds the state enum dcache_state_t, WORD_W=32, BYTE_OFF=2 and the default STATS_ADDR.
- Line arrays stay local, since their width depends on parameters.
- Sub-module dcache_lru, parametrised (SETS, WAYS):
  - Inputs: touch_en, touch_set, touch_way.
  - Output: victim_way for a queried set; it prefers invalid ways, given a valid mask input.
  - Holds the age arrays and resets them to way index order.

Test Plan:
- Read 0x0000_0040 cold, dwait=0, memory word = address → FETCH of 0x40 and 0x44; dhit one cycle later; dmemload=0x40; exactly 2 dREN transfers.
- Write 0xDEADBEEF to 0x44 after the fill → dhit the same cycle; a read of 0x44 returns 0xDEADBEEF; no memory traffic.
- WAYS=2: fill tags A, B at index 0, dirty A, touch B, miss on tag C → WB writes A's two words, FETCH loads C, B stays resident.
- WAYS=4, SETS=4: access tags 0,1,2,3,0,4 at one index → the tag 1 line is evicted and the other tags still hit.
- dwait held high for 3 cycles on each word during WB → daddr and dstore are stable; the line state changes only after the final accept.
- Halt with 3 dirty lines, BLOCK_WORDS=2, STATS on, 5 hits → 6 data writes in set/way order, then 5 written to 0x3100 and the miss count to 0x3104; flushed=1 and stays high.
